// File: rtl/rv_pkg.sv
// Shared definitions for the branch predictor: BHT counter encodings,
// the counter reset value and the controller FSM state type.
package rv_pkg;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_t;

  localparam logic [1:0] BHT_RESET = BHT_WNT;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } bp_state_t;

endpackage

// File: rtl/sat_cnt2.sv
// Next-state function of a 2-bit saturating up/down counter used for
// each BHT entry. Counts up on taken, down on not-taken, sticks at the ends.
module sat_cnt2
  import rv_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_up,
  output logic [1:0] o_cnt
);

  // Saturating step: hold at strong-taken going up, strong-not-taken going down
  always_comb begin
    o_cnt = i_cnt;
    if (i_up) begin
      if (i_cnt != BHT_ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != BHT_SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch sequencing controller: predicts ID-stage conditional branches from a
// direct-mapped table of 2-bit counters, resolves them in EX, issues PC
// redirects and pipeline flushes, and counts resolved and mispredicted branches.
module branch_pred_ctrl
  import rv_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_id_valid,
  input  logic             i_id_is_branch,
  input  logic [31:0]      i_id_pc,
  input  logic [31:0]      i_id_target,
  output logic             o_id_pred_taken,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_branch,
  input  logic [31:0]      i_ex_pc,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_pred_taken,
  input  logic             i_ex_taken,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       r_bht [ENTRIES];
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mispred_count;
  bp_state_t        r_state;
  bp_state_t        w_state_next;

  logic [IDX_W-1:0] w_id_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_next_cnt;
  logic             w_ex_br;
  logic             w_mispred;
  logic             w_update;
  logic             w_pred_en;
  logic             w_id_pred;
  logic             w_unused_pc_bits;

  assign w_id_idx         = i_id_pc[IDX_W+1:2];
  assign w_ex_idx         = i_ex_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{i_id_pc[31:IDX_W+2], i_id_pc[1:0]};

  assign w_ex_br   = i_ex_valid & i_ex_is_branch;
  assign w_mispred = w_ex_br & (i_ex_taken != i_ex_pred_taken);
  assign w_update  = w_ex_br & ~i_stall;

  // The only write port of the table: next value of the entry being resolved
  sat_cnt2 u_sat_cnt2 (
    .i_cnt (r_bht[w_ex_idx]),
    .i_up  (i_ex_taken),
    .o_cnt (w_next_cnt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // FSM next state: a resolved mispredict opens one recovery cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:     if (w_update && w_mispred) w_state_next = ST_RECOVER;
      ST_RECOVER: if (!i_stall)              w_state_next = ST_RUN;
      default:                               w_state_next = ST_RUN;
    endcase
  end

  // FSM output: ID holds a squashed bubble during recovery, so no prediction
  always_comb begin
    w_pred_en = 1'b0;
    if (r_state == ST_RUN) w_pred_en = 1'b1;
  end

  assign w_id_pred = i_id_valid & i_id_is_branch & r_bht[w_id_idx][1] & w_pred_en;

  // Redirect selection: EX mispredict outranks an ID taken prediction; nothing leaves while in reset
  always_comb begin
    o_id_pred_taken = w_id_pred & rst_n;
    o_redirect      = 1'b0;
    o_redirect_pc   = 32'h0;
    o_flush_if_id   = 1'b0;
    o_flush_id_ex   = 1'b0;
    if (rst_n) begin
      if (w_mispred) begin
        o_redirect    = 1'b1;
        o_redirect_pc = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end else if (w_id_pred) begin
        o_redirect    = 1'b1;
        o_redirect_pc = i_id_target;
        o_flush_if_id = 1'b1;
      end
    end
  end

  // Table is a flop array so every entry clears asynchronously; ID reads see the pre-update value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= BHT_RESET;
    end else if (w_update) begin
      r_bht[w_ex_idx] <= w_next_cnt;
    end
  end

  // Statistics counters, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_update) begin
      if (r_br_count != {CNT_W{1'b1}})
        r_br_count <= r_br_count + CNT_W'(1);
      if (w_mispred && (r_mispred_count != {CNT_W{1'b1}}))
        r_mispred_count <= r_mispred_count + CNT_W'(1);
    end
  end

  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;

endmodule
